// File: rtl/pixel_fp_loader.sv
// pixel_fp_loader: streams NUM_WORDS unsigned pixels into an FP register stage,
// converting each to IEEE-754 single precision on the way through.
//
//   state | meaning
//   IDLE  | waiting for start
//   CLEAR | one-cycle clear pulse to the FP stage, accept counter zeroed
//   LOAD  | accepting pixels until NUM_WORDS have been taken
//   DRAIN | last converted word is presented on fp_data
//   DONE  | vec_done pulse, then back to IDLE
module pixel_fp_loader #(
  parameter int NUM_WORDS = 32,
  parameter int PIX_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  output logic             fp_en,
  output logic             fp_clear,
  output logic [31:0]      fp_data,
  output logic             busy,
  output logic             vec_done
);

  localparam int CW = $clog2(NUM_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            fp_en_q, fp_en_d;
  logic [31:0]     fp_data_q, fp_data_d;
  logic            accept;

  // Integers below 2^24 are exactly representable, so the conversion is a
  // leading-one search plus a normalising shift; no rounding is involved.
  function automatic logic [31:0] pix_to_fp(input logic [PIX_W-1:0] v);
    logic [23:0] ext;
    logic [4:0]  p;
    logic [22:0] mant;
    logic [7:0]  expo;
    logic [31:0] res;
    ext = 24'(v);
    p   = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (ext[i]) p = 5'(i);
    end
    mant = 23'(ext << (5'd23 - p));
    expo = 8'd127 + {3'b000, p};
    if (ext == 24'd0) res = 32'h0000_0000;
    else              res = {1'b0, expo, mant};
    return res;
  endfunction

  // State, counter and output-stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      fp_en_q   <= 1'b0;
      fp_data_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fp_en_q   <= fp_en_d;
      fp_data_q <= fp_data_d;
    end
  end

  // Next-state and state-decoded outputs; abort blocks the accept in its own cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pix_ready = 1'b0;
    fp_clear  = 1'b0;
    busy      = 1'b1;
    vec_done  = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        fp_clear = 1'b1;
        cnt_d    = '0;
        state_d  = abort ? S_IDLE : S_LOAD;
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          pix_ready = 1'b1;
          accept    = pix_valid;
          if (accept) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NUM_WORDS - 1)) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = abort ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        vec_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Reset must silence outputs in the very cycle it is asserted, not one later.
    if (rst) begin
      pix_ready = 1'b0;
      fp_clear  = 1'b0;
      busy      = 1'b0;
      vec_done  = 1'b0;
      accept    = 1'b0;
    end
  end

  // Convert the accepted pixel; fp_data holds between accepts.
  always_comb begin
    fp_en_d   = accept;
    fp_data_d = fp_data_q;
    if (accept) fp_data_d = pix_to_fp(pix_data);
  end

  assign fp_en   = fp_en_q & ~rst;
  assign fp_data = rst ? 32'h0000_0000 : fp_data_q;

endmodule

// File: tb/tb_pixel_fp_loader.sv
// Directed bench for pixel_fp_loader: cycle-exact control timelines with
// hand-derived expectations; converted words checked against constants and a
// double-precision reference.
module tb_pixel_fp_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        fp_en;
  logic        fp_clear;
  logic [31:0] fp_data;
  logic        busy;
  logic        vec_done;
  logic [4:0]  ctrl;

  int vectors;
  int miscompares;

  pixel_fp_loader #(.NUM_WORDS(32), .PIX_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .fp_en     (fp_en),
    .fp_clear  (fp_clear),
    .fp_data   (fp_data),
    .busy      (busy),
    .vec_done  (vec_done)
  );

  assign ctrl = {pix_ready, fp_clear, fp_en, vec_done, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference conversion through the simulator's double representation.
  function automatic logic [31:0] fp_ref(input int v);
    real         r;
    logic [63:0] b;
    logic [10:0] e;
    if (v == 0) return 32'h0000_0000;
    r = v;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b0; pix_valid = 1'b1; pix_data = 8'hFF;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (ctrl !== 5'b00000) begin
        miscompares++;
        $display("FAIL reset_ctrl c=%0d got=%b exp=00000", c, ctrl);
      end
      vectors++;
      if (fp_data !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_fp_data c=%0d got=%h exp=00000000", c, fp_data);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; start = 1'b0; pix_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctrl !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_release got=%b exp=00000", ctrl);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_load(input bit poke_start);
    logic [7:0]  pix [32];
    logic [31:0] kconst [4];
    logic [31:0] want;
    logic [31:0] last;
    logic [4:0]  exp;
    kconst[0] = 32'h0000_0000; kconst[1] = 32'h3F80_0000;
    kconst[2] = 32'h4300_0000; kconst[3] = 32'h437F_0000;
    for (int i = 0; i < 32; i++) pix[i] = 8'((i * 37 + 11) & 255);
    pix[0] = 8'd0; pix[1] = 8'd1; pix[2] = 8'd128; pix[3] = 8'd255;
    last = 32'h0;
    for (int c = 0; c < 38; c++) begin
      start     = (c == 0) || (poke_start && (c == 10 || c == 34 || c == 35));
      abort     = 1'b0;
      pix_valid = 1'b1;
      pix_data  = (c >= 2 && c <= 33) ? pix[c-2] : 8'hEE;
      @(negedge clk);
      exp = {(c >= 2 && c <= 33), (c == 1), (c >= 3 && c <= 34), (c == 35), (c >= 1 && c <= 35)};
      vectors++;
      if (ctrl !== exp) begin
        miscompares++;
        $display("FAIL full_load_ctrl poke=%0d c=%0d got=%b exp=%b", poke_start, c, ctrl, exp);
      end
      if (c >= 3 && c <= 34) begin
        want = (c - 3 < 4) ? kconst[c-3] : fp_ref(int'(pix[c-3]));
        last = want;
        vectors++;
        if (fp_data !== want) begin
          miscompares++;
          $display("FAIL full_load_data c=%0d pix=%0d got=%h exp=%h", c, pix[c-3], fp_data, want);
        end
      end else if (c >= 35) begin
        vectors++;
        if (fp_data !== last) begin
          miscompares++;
          $display("FAIL full_load_hold c=%0d got=%h exp=%h", c, fp_data, last);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0; pix_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0]  pix [32];
    logic [31:0] want;
    logic [4:0]  exp;
    int n_en;
    int n_done;
    n_en = 0; n_done = 0;
    for (int i = 0; i < 32; i++) pix[i] = 8'((i * 13 + 200) & 255);
    for (int c = 0; c < 70; c++) begin
      start     = (c == 0);
      abort     = 1'b0;
      pix_valid = ((c % 2) == 0);
      pix_data  = (c >= 2 && c <= 64 && (c % 2) == 0) ? pix[(c-2)/2] : 8'h55;
      @(negedge clk);
      exp = {(c >= 2 && c <= 64), (c == 1), (c >= 3 && c <= 65 && (c % 2) == 1),
             (c == 66), (c >= 1 && c <= 66)};
      vectors++;
      if (ctrl !== exp) begin
        miscompares++;
        $display("FAIL backpressure_ctrl c=%0d got=%b exp=%b", c, ctrl, exp);
      end
      if (fp_en === 1'b1) n_en++;
      if (vec_done === 1'b1) n_done++;
      if (c >= 3 && c <= 65 && (c % 2) == 1) begin
        want = fp_ref(int'(pix[(c-3)/2]));
        vectors++;
        if (fp_data !== want) begin
          miscompares++;
          $display("FAIL backpressure_data c=%0d got=%h exp=%h", c, fp_data, want);
        end
      end
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    vectors++;
    if (n_en !== 32) begin
      miscompares++;
      $display("FAIL backpressure_en_count got=%0d exp=32", n_en);
    end
    vectors++;
    if (n_done !== 1) begin
      miscompares++;
      $display("FAIL backpressure_done_count got=%0d exp=1", n_done);
    end
  endtask

  task automatic test_abort();
    int          ac_tab [3];
    int          ac;
    logic [31:0] want;
    logic [4:0]  exp;
    ac_tab[0] = 12; ac_tab[1] = 1; ac_tab[2] = 34;
    for (int s = 0; s < 3; s++) begin
      ac = ac_tab[s];
      for (int c = 0; c < 38; c++) begin
        start     = (c == 0);
        abort     = (c == 0) || (c == ac);
        pix_valid = 1'b1;
        pix_data  = 8'(c * 3);
        @(negedge clk);
        exp = {(c >= 2 && c <= 33 && c < ac), (c == 1), (c >= 3 && c <= 34 && c <= ac),
               1'b0, (c >= 1 && c <= ac)};
        vectors++;
        if (ctrl !== exp) begin
          miscompares++;
          $display("FAIL abort_ctrl ac=%0d c=%0d got=%b exp=%b", ac, c, ctrl, exp);
        end
        if (c >= 3 && c <= 34 && c <= ac) begin
          want = fp_ref((c - 1) * 3);
          vectors++;
          if (fp_data !== want) begin
            miscompares++;
            $display("FAIL abort_data ac=%0d c=%0d got=%h exp=%h", ac, c, fp_data, want);
          end
        end
        @(posedge clk); #1;
      end
    end
    abort = 1'b0; pix_valid = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] want;
    logic [4:0]  exp;
    for (int c = 0; c < 26; c++) begin
      start     = (c == 0);
      abort     = 1'b0;
      rst       = (c == 21);
      pix_valid = 1'b1;
      pix_data  = 8'(c + 40);
      @(negedge clk);
      exp = {(c >= 2 && c <= 20), (c == 1), (c >= 3 && c <= 20), 1'b0, (c >= 1 && c <= 20)};
      vectors++;
      if (ctrl !== exp) begin
        miscompares++;
        $display("FAIL reset_mid_ctrl c=%0d got=%b exp=%b", c, ctrl, exp);
      end
      if (c >= 3 && c <= 20) begin
        want = fp_ref(c - 1 + 40);
        vectors++;
        if (fp_data !== want) begin
          miscompares++;
          $display("FAIL reset_mid_data c=%0d got=%h exp=%h", c, fp_data, want);
        end
      end else if (c >= 21) begin
        vectors++;
        if (fp_data !== 32'h0) begin
          miscompares++;
          $display("FAIL reset_mid_fp_zero c=%0d got=%h exp=00000000", c, fp_data);
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; pix_valid = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pix_valid = 1'b0; pix_data = 8'h00;
    test_reset();
    test_full_load(1'b0);
    test_backpressure();
    test_abort();
    test_full_load(1'b0);
    test_reset_mid_load();
    test_full_load(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pixel_fp_loader.md
PIXEL_FP_LOADER -- requirements
Module: pixel_fp_loader

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 32: pixels per vector, i.e. the number of shift-register entries filled per load.
REQ-002 SHALL have parameter PIX_W, default 8: input pixel width in bits; legal range 1..24.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1: begins a vector load; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1: cancels a load in progress.
REQ-007 SHALL have port pix_valid  input  1: pixel source has data.
REQ-008 SHALL have port pix_data  input  PIX_W: unsigned integer pixel.
REQ-009 SHALL have port pix_ready  output  1: loader accepts a pixel this cycle.
REQ-010 SHALL have port fp_en  output  1: shift enable to the FP register stage.
REQ-011 SHALL have port fp_clear  output  1: clear to the FP register stage.
REQ-012 SHALL have port fp_data  output  32: IEEE-754 single-precision value of the pixel.
REQ-013 SHALL have port busy  output  1: high in every state except IDLE.
REQ-014 SHALL have port vec_done  output  1: one-cycle pulse when a full vector has been shifted out.

Function
REQ-015 SHALL implement FSM states IDLE, CLEAR, LOAD, DRAIN, DONE.
REQ-016 SHALL go IDLE->CLEAR on start=1; SHALL ignore start in every other state.
REQ-017 SHALL assert fp_clear for exactly the one cycle spent in CLEAR, zero the accept counter, then go to LOAD.
REQ-018 SHALL drive pix_ready=1 only in LOAD; accept = pix_valid & pix_ready.
REQ-019 SHALL count accepts; on the NUM_WORDS-th accept go to DRAIN the next cycle, so pix_ready is 0 after that accept.
REQ-020 SHALL register each accepted pixel's conversion into fp_data, with fp_en=1 exactly one cycle after the accept (latency 1) and fp_en=0 otherwise.
REQ-021 SHALL hold fp_data when fp_en=0.
REQ-022 SHALL go DRAIN->DONE after one cycle; that DRAIN cycle carries fp_en for the last word.
REQ-023 SHALL assert vec_done for the single DONE cycle, then return to IDLE.
REQ-024 SHALL accept at most one pixel per cycle; back-to-back accepts yield back-to-back fp_en; gaps in pix_valid yield matching fp_en gaps, with no loss or duplication.
REQ-025 SHALL convert pixel 0 to 0x00000000.
REQ-026 SHALL convert nonzero pixel v as follows, exactly with no rounding:
- p = index of the most-significant 1 of v;
- sign = 0;
- exponent = 127+p;
- mantissa[22:0] = v shifted left by (23-p) with the leading 1 dropped.
REQ-027 SHALL, on abort=1 in CLEAR, LOAD or DRAIN, go to IDLE next cycle:
- suppress any pending fp_en;
- pulse no vec_done;
- deassert pix_ready in that same cycle;
- abort has priority over an accept in the same cycle.
REQ-028 SHALL ignore abort in IDLE and DONE.
REQ-029 SHALL keep fp_clear and fp_en mutually exclusive.

Reset
REQ-030 SHALL, while rst=1, force state IDLE, counter 0, pix_ready=0, fp_en=0, fp_clear=0, fp_data=0x00000000, busy=0, vec_done=0.
REQ-031 SHALL give rst priority over start, abort and accepts.
REQ-032 SHALL, on rst asserted mid-load, discard partial progress; the next start begins a fresh vector with a new CLEAR.

Verification
REQ-033 Conversion: load pixels 0, 1, 128, 255 -> fp_data 0x00000000, 0x3F800000, 0x43000000, 0x437F0000.
REQ-034 Full load, NUM_WORDS=32, pix_valid held high, start in cycle 0 -> fp_clear in cycle 1, accepts in cycles 2..33, fp_en in cycles 3..34, vec_done in cycle 35, busy=0 from cycle 36.
REQ-035 Backpressure: pix_valid toggled 1,0,1,0... -> 32 fp_en pulses, each one cycle after its accept, data in input order, exactly one vec_done.
REQ-036 Abort after 10 accepts -> no fp_en after the next cycle, no vec_done, IDLE next cycle; a subsequent start produces fp_clear and a full 32-word load.
REQ-037 rst asserted in LOAD at accept 20 -> all outputs 0 the next cycle; start pulsed during LOAD, DRAIN or DONE -> no effect.
